// File: rtl/ppm_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ppm_encoder_pkg
//  Purpose  : Shared PPM timing definitions (symbol, slot, pulse, SOF and EOF
//             chip boundaries) used by the encoder and a matching decoder.
//  Revision : 1.0  initial release
// ============================================================================
package ppm_encoder_pkg;

  // Symbol geometry in chips (one chip per clock)
  localparam logic [7:0] c_SYM_LEN  = 8'd128;
  localparam logic [7:0] c_SLOT_W   = 8'd32;
  localparam logic [7:0] c_PULSE_W  = 8'd16;

  // SOF pattern: low 0..15, high 16..79, low 80..95, high 96..127
  localparam logic [7:0] c_SOF_B0   = 8'd16;
  localparam logic [7:0] c_SOF_B1   = 8'd80;
  localparam logic [7:0] c_SOF_B2   = 8'd96;

  // EOF pulse starts at this chip and lasts one pulse width
  localparam logic [7:0] c_EOF_OFS  = 8'd32;

  // Last count of the 7-bit symbol counter
  localparam logic [6:0] c_CNT_LAST = 7'(c_SYM_LEN - 8'd1);

  // Symbol type fed to the chip generator
  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_SOF  = 2'd1,
    MODE_DATA = 2'd2,
    MODE_EOF  = 2'd3
  } mode_t;

  // True when pos lies in [lo, lo+len)
  function automatic logic in_window(input logic [7:0] pos,
                                     input logic [7:0] lo,
                                     input logic [7:0] len);
    return (pos >= lo) && (pos < (lo + len));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppm_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : ppm_encoder_if
//  Purpose  : Byte input handshake and PPM line outputs of the encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface ppm_encoder_if;
  logic [7:0] Din;
  logic       D_en;
  logic       D_last;
  logic       D_rdy;
  logic       Dout;
  logic       busy;
  logic       underrun;

  // Byte source / line observer side
  modport master (
    output Din, D_en, D_last,
    input  D_rdy, Dout, busy, underrun
  );

  // Encoder side
  modport slave (
    input  Din, D_en, D_last,
    output D_rdy, Dout, busy, underrun
  );
endinterface
`default_nettype wire

// File: rtl/ppm_symbol_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ppm_symbol_gen
//  Purpose  : Maps (symbol mode, data value k, chip count) to the line level.
//             Output is 0 inside a pulse, 1 otherwise; purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module ppm_symbol_gen
  import ppm_encoder_pkg::*;
(
  input  mode_t      i_mode,
  input  logic [1:0] i_k,
  input  logic [6:0] i_cnt,
  output logic       o_chip
);

  logic [7:0] w_pos;
  logic [7:0] w_slot_lo;
  logic       w_low;

  // Decide whether the current chip falls inside a pulse
  always_comb begin
    w_pos     = {1'b0, i_cnt};
    // Data pulse sits in the second half of slot k
    w_slot_lo = ({6'd0, i_k} * c_SLOT_W) + (c_SLOT_W - c_PULSE_W);
    w_low     = 1'b0;
    case (i_mode)
      MODE_SOF:  w_low = in_window(w_pos, 8'd0, c_SOF_B0) ||
                         in_window(w_pos, c_SOF_B1, c_SOF_B2 - c_SOF_B1);
      MODE_DATA: w_low = in_window(w_pos, w_slot_lo, c_PULSE_W);
      MODE_EOF:  w_low = in_window(w_pos, c_EOF_OFS, c_PULSE_W);
      default:   w_low = 1'b0;
    endcase
    o_chip = ~w_low;
  end

endmodule
`default_nettype wire

// File: rtl/ppm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : ppm_encoder
//  Purpose  : Byte-stream to 4-PPM line encoder. Frame = SOF symbol, four
//             symbols per byte (LS bit pair first), EOF symbol, idle gap.
//             All outputs are registered from next-state values so that the
//             line changes exactly on the chip boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module ppm_encoder
  import ppm_encoder_pkg::*;
#(
  parameter int GAP_CLKS = 128
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ppm_encoder_if.slave     bus
);

  localparam int c_GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_CLKS - 1);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_SOF  = 3'd1;
  localparam logic [2:0] c_ST_DATA = 3'd2;
  localparam logic [2:0] c_ST_EOF  = 3'd3;
  localparam logic [2:0] c_ST_GAP  = 3'd4;

  logic [2:0]      r_state;
  logic [6:0]      r_cnt;
  logic [1:0]      r_sym;
  logic [7:0]      r_byte;
  logic            r_last;
  logic [c_GW-1:0] r_gap;
  logic            r_dout;
  logic            r_rdy;
  logic            r_busy;
  logic            r_under;

  logic [2:0]      w_state_nx;
  logic [6:0]      w_cnt_nx;
  logic [1:0]      w_sym_nx;
  logic [7:0]      w_byte_nx;
  logic            w_last_nx;
  logic [c_GW-1:0] w_gap_nx;
  logic            w_under_nx;
  logic            w_rdy_nx;
  logic            w_accept;
  logic            w_sym_end;
  mode_t           w_mode_nx;
  logic            w_chip_nx;

  // Next-state, counter and shift-register logic
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 7'd1;
    w_sym_nx   = r_sym;
    w_byte_nx  = r_byte;
    w_last_nx  = r_last;
    w_gap_nx   = r_gap;
    w_under_nx = 1'b0;
    w_accept   = bus.D_en && r_rdy;
    w_sym_end  = (r_cnt == c_CNT_LAST);
    case (r_state)
      c_ST_IDLE: begin
        w_cnt_nx = 7'd0;
        if (w_accept) begin
          w_state_nx = c_ST_SOF;
          w_byte_nx  = bus.Din;
          w_last_nx  = bus.D_last;
          w_sym_nx   = 2'd0;
          w_gap_nx   = '0;
        end
      end
      c_ST_SOF: begin
        if (w_sym_end) begin
          w_state_nx = c_ST_DATA;
          w_sym_nx   = 2'd0;
        end
      end
      c_ST_DATA: begin
        if (w_sym_end) begin
          if (r_sym != 2'd3) begin
            w_sym_nx  = r_sym + 2'd1;
            w_byte_nx = {2'b00, r_byte[7:2]};
          end else if (w_accept) begin
            // Back-to-back byte: next symbol starts without a gap
            w_sym_nx  = 2'd0;
            w_byte_nx = bus.Din;
            w_last_nx = bus.D_last;
          end else begin
            w_state_nx = c_ST_EOF;
            w_under_nx = ~r_last;
          end
        end
      end
      c_ST_EOF: begin
        if (w_sym_end) begin
          w_state_nx = c_ST_GAP;
          w_gap_nx   = '0;
        end
      end
      c_ST_GAP: begin
        w_cnt_nx = 7'd0;
        w_gap_nx = r_gap + c_GW'(1);
        if (r_gap == c_GAP_LAST) begin
          w_state_nx = c_ST_IDLE;
          w_gap_nx   = '0;
        end
      end
      default: begin
        w_state_nx = c_ST_IDLE;
        w_cnt_nx   = 7'd0;
      end
    endcase

    // Ready only in IDLE or at the very last chip of a non-final byte
    w_rdy_nx = (w_state_nx == c_ST_IDLE) ||
               ((w_state_nx == c_ST_DATA) && (w_cnt_nx == c_CNT_LAST) &&
                (w_sym_nx == 2'd3) && !w_last_nx);

    case (w_state_nx)
      c_ST_SOF:  w_mode_nx = MODE_SOF;
      c_ST_DATA: w_mode_nx = MODE_DATA;
      c_ST_EOF:  w_mode_nx = MODE_EOF;
      default:   w_mode_nx = MODE_IDLE;
    endcase
  end

  ppm_symbol_gen u_symbol_gen (
    .i_mode (w_mode_nx),
    .i_k    (w_byte_nx[1:0]),
    .i_cnt  (w_cnt_nx),
    .o_chip (w_chip_nx)
  );

  // State and registered outputs; reset aborts any frame with the line high
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 7'd0;
      r_sym   <= 2'd0;
      r_byte  <= 8'd0;
      r_last  <= 1'b0;
      r_gap   <= '0;
      r_dout  <= 1'b1;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sym   <= w_sym_nx;
      r_byte  <= w_byte_nx;
      r_last  <= w_last_nx;
      r_gap   <= w_gap_nx;
      r_dout  <= w_chip_nx;
      r_rdy   <= w_rdy_nx;
      r_busy  <= (w_state_nx != c_ST_IDLE);
      r_under <= w_under_nx;
    end
  end

  assign bus.Dout     = r_dout;
  assign bus.D_rdy    = r_rdy;
  assign bus.busy     = r_busy;
  assign bus.underrun = r_under;

endmodule
`default_nettype wire

// File: tb/tb_ppm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppm_encoder
//  Purpose  : Self-checking bench for ppm_encoder: table of single-byte frames
//             with hand-computed pulse positions, plus multi-byte, underrun,
//             gap-hold and mid-frame reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ppm_encoder;

  localparam int GAP = 128;
  localparam int SYM = 128;
  localparam int TRN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ppm_encoder_if bus ();

  ppm_encoder #(.GAP_CLKS(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] din;
    logic       last;
  } item_t;

  // Pulse start (first low chip) of each data symbol, st[i] = symbol i
  typedef struct packed {
    logic [7:0]      din;
    logic [3:0][7:0] st;
  } vec_t;

  item_t feed_q[$];
  int    acc_idx[$];
  int    exp_st[$];
  logic  tr_dout  [TRN];
  logic  tr_rdy   [TRN];
  logic  tr_busy  [TRN];
  logic  tr_under [TRN];
  int    ncyc;
  int    n_cmp = 0;
  int    n_bad = 0;
  vec_t  vt [8];

  // One clock: note acceptance, record outputs, then drive the next inputs
  task automatic step();
    logic rdy_b, en_b, rst_b;
    rdy_b = bus.D_rdy;
    en_b  = bus.D_en;
    rst_b = rst;
    @(posedge clk);
    #1;
    if (rdy_b && en_b && rst_b) begin
      acc_idx.push_back(ncyc);
      if (feed_q.size() > 0) void'(feed_q.pop_front());
    end
    if (ncyc < TRN) begin
      tr_dout[ncyc]  = bus.Dout;
      tr_rdy[ncyc]   = bus.D_rdy;
      tr_busy[ncyc]  = bus.busy;
      tr_under[ncyc] = bus.underrun;
    end
    ncyc++;
    if (feed_q.size() > 0) begin
      bus.D_en   = 1'b1;
      bus.Din    = feed_q[0].din;
      bus.D_last = feed_q[0].last;
    end else begin
      bus.D_en   = 1'b0;
      bus.Din    = 8'h00;
      bus.D_last = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic get(input int i, input int which);
    if (i < 0 || i >= TRN) return 1'bx;
    case (which)
      0: return tr_dout[i];
      1: return tr_rdy[i];
      2: return tr_busy[i];
      default: return tr_under[i];
    endcase
  endfunction

  function automatic int count(input int a, input int b, input int which, input logic val);
    int n = 0;
    for (int i = a; i < b; i++) if (get(i, which) === val) n++;
    return n;
  endfunction

  // Bit i set when the line is low at chip i of the symbol starting at s
  function automatic logic [127:0] trace_mask(input int s);
    logic [127:0] m = '0;
    for (int i = 0; i < SYM; i++) m[i] = (get(s + i, 0) === 1'b0);
    return m;
  endfunction

  function automatic logic [127:0] win(input int st, input int len);
    logic [127:0] m = '0;
    for (int i = st; i < st + len; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int pulse_start(input int s);
    for (int i = 0; i < SYM; i++) if (get(s + i, 0) === 1'b0) return i;
    return -1;
  endfunction

  task automatic clear_trace();
    ncyc = 0;
    acc_idx.delete();
  endtask

  task automatic load_exp(input vec_t v);
    for (int i = 0; i < 4; i++) exp_st.push_back(int'(v.st[i]));
  endtask

  task automatic wait_accept(input string tag, input int nth, output int s);
    for (int i = 0; i < 40 && acc_idx.size() < nth; i++) step();
    chk({tag, ".accept"}, 128'(acc_idx.size() >= nth), 128'(1));
    s = (acc_idx.size() >= nth) ? acc_idx[nth-1] : 0;
  endtask

  task automatic run_to(input int idx);
    while (ncyc <= idx) step();
  endtask

  // Full frame check against exp_st; returns index of the first IDLE sample
  task automatic check_frame(input string tag, input int s, output int e_idle);
    int nd, e;
    nd = exp_st.size();
    chk({tag, ".sof"}, trace_mask(s), win(0, 16) | win(80, 16));
    for (int i = 0; i < nd; i++)
      chk($sformatf("%s.d%0d", tag, i), trace_mask(s + SYM * (1 + i)), win(exp_st[i], 16));
    e = s + SYM * (1 + nd);
    chk({tag, ".eof"}, trace_mask(e), win(32, 16));
    chk({tag, ".gap_low"}, 128'(count(e + SYM, e + SYM + GAP, 0, 1'b0)), 128'(0));
    chk({tag, ".busy_len"}, 128'(count(s, e + SYM + GAP, 2, 1'b1)), 128'(e + SYM + GAP - s));
    chk({tag, ".end_busy_rdy"}, 128'({get(e + SYM + GAP, 2), get(e + SYM + GAP, 1)}), 128'(2'b01));
    e_idle = e + SYM + GAP;
  endtask

  initial begin
    int s, s2, e_idle, e2, b;
    bus.Din    = 8'h00;
    bus.D_en   = 1'b0;
    bus.D_last = 1'b0;

    vt[0] = '{din: 8'h1B, st: {8'd16,  8'd48,  8'd80,  8'd112}};
    vt[1] = '{din: 8'h00, st: {8'd16,  8'd16,  8'd16,  8'd16}};
    vt[2] = '{din: 8'hFF, st: {8'd112, 8'd112, 8'd112, 8'd112}};
    vt[3] = '{din: 8'hA5, st: {8'd80,  8'd80,  8'd48,  8'd48}};
    vt[4] = '{din: 8'h4E, st: {8'd48,  8'd16,  8'd112, 8'd80}};
    vt[5] = '{din: 8'h93, st: {8'd80,  8'd48,  8'd16,  8'd112}};
    vt[6] = '{din: 8'h3C, st: {8'd16,  8'd112, 8'd112, 8'd16}};
    vt[7] = '{din: 8'hC3, st: {8'd112, 8'd16,  8'd16,  8'd112}};

    // Reset state and first ready after release
    clear_trace();
    bus.D_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("reset.outputs", 128'({bus.Dout, bus.D_rdy, bus.busy, bus.underrun}), 128'(4'b1000));
    rst = 1'b1;
    step();
    chk("reset.rdy_after_release", 128'(bus.D_rdy), 128'(1));

    // Single-byte frames from the table
    for (int v = 0; v < 8; v++) begin
      clear_trace();
      exp_st.delete();
      feed_q.push_back('{din: vt[v].din, last: 1'b1});
      wait_accept($sformatf("v%0d", v), 1, s);
      run_to(s + 6 * SYM + GAP + 1);
      load_exp(vt[v]);
      check_frame($sformatf("v%0d_%h", v, vt[v].din), s, e_idle);
      chk($sformatf("v%0d.rdy_in_frame", v), 128'(count(s, e_idle, 1, 1'b1)), 128'(0));
      chk($sformatf("v%0d.underrun", v), 128'(count(s, e_idle + 1, 3, 1'b1)), 128'(0));
    end

    // Three bytes back-to-back
    clear_trace();
    exp_st.delete();
    feed_q.push_back('{din: 8'h00, last: 1'b0});
    feed_q.push_back('{din: 8'hFF, last: 1'b0});
    feed_q.push_back('{din: 8'hA5, last: 1'b1});
    wait_accept("multi", 1, s);
    run_to(s + 14 * SYM + GAP + 1);
    load_exp(vt[1]);
    load_exp(vt[2]);
    load_exp(vt[3]);
    check_frame("multi", s, e_idle);
    chk("multi.accepts", 128'(acc_idx.size()), 128'(3));
    chk("multi.rdy_count", 128'(count(s, e_idle, 1, 1'b1)), 128'(2));
    chk("multi.rdy_pos", 128'({get(s + 5 * SYM - 1, 1), get(s + 9 * SYM - 1, 1)}), 128'(2'b11));
    chk("multi.underrun", 128'(count(s, e_idle + 1, 3, 1'b1)), 128'(0));
    for (int j = 0; j < 3; j++) begin
      b = 0;
      for (int i = 0; i < 4; i++)
        b |= ((pulse_start(s + SYM * (1 + 4 * j + i)) - 16) / 32) << (2 * i);
      chk($sformatf("multi.decode%0d", j), 128'(b), 128'(vt[j + 1].din));
    end

    // Underrun: D_en low at the boundary, second byte held until IDLE
    clear_trace();
    exp_st.delete();
    feed_q.push_back('{din: 8'h3C, last: 1'b0});
    wait_accept("under", 1, s);
    run_to(s + 5 * SYM);
    feed_q.push_back('{din: 8'hC3, last: 1'b1});
    run_to(s + 6 * SYM + GAP + 1);
    load_exp(vt[6]);
    check_frame("under", s, e_idle);
    chk("under.pulse_pos", 128'(get(s + 5 * SYM, 3)), 128'(1));
    chk("under.pulse_count", 128'(count(s, e_idle, 3, 1'b1)), 128'(1));
    chk("under.rdy_count", 128'(count(s, e_idle, 1, 1'b1)), 128'(1));
    wait_accept("under2", 2, s2);
    chk("gap_hold.sof_start", 128'(s2), 128'(s + 6 * SYM + GAP + 1));
    run_to(s2 + 6 * SYM + GAP + 1);
    exp_st.delete();
    load_exp(vt[7]);
    check_frame("under2", s2, e2);

    // Reset at count 60 of the second data symbol
    clear_trace();
    feed_q.push_back('{din: 8'h55, last: 1'b0});
    feed_q.push_back('{din: 8'h66, last: 1'b1});
    wait_accept("rstmid", 1, s);
    run_to(s + 2 * SYM + 60);
    chk("rstmid.pre_low", 128'(bus.Dout), 128'(0));
    rst = 1'b0;
    feed_q.delete();
    step();
    chk("rstmid.abort", 128'({bus.Dout, bus.busy, bus.D_rdy}), 128'(3'b100));
    step();
    step();
    rst = 1'b1;
    step();
    chk("rstmid.rdy_after_release", 128'({bus.D_rdy, bus.Dout, bus.busy}), 128'(3'b110));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
